if_byte_fetch: RTL and testbench
================================

# if_byte_fetch

Instruction-fetch front end for the pipelined TinyRISC core. It generates byte addresses into the byte-wide instruction memory and assembles four big-endian bytes into each 32-bit instruction. Completed instructions and their PCs are buffered in a small FIFO and handed to the IF/ID register through a valid/ready handshake. Taken branches from downstream redirect the PC and squash all fetched and in-flight work.

## Interface
- ADDR_W, 32, width of PC and instruction-memory byte address
- DEPTH, 2, output FIFO entries (power of two, ≥2)
- RESET_PC, 0, fetch address after reset (word aligned)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- imem_en  out  1  byte read request this cycle
- imem_addr  out  ADDR_W  byte address of request
- imem_rdata  in  8  read data, valid the cycle after imem_en=1
- redirect  in  1  taken branch/jump; flush and refetch
- redirect_pc  in  ADDR_W  new fetch address
- out_valid  out  1  FIFO head holds an instruction
- out_ready  in  1  consumer accepts head this cycle
- out_instr  out  32  instruction at FIFO head
- out_pc  out  ADDR_W  byte address of out_instr

## Operation
- State: fetch_pc, byte_cnt (0..3), asm register (32b), rd_pending flag (a returning byte is expected), FIFO with count (0..DEPTH).
- FSM: ISSUE (imem_en=1, imem_addr=fetch_pc+byte_cnt) and HOLD (imem_en=0).
- ISSUE: byte_cnt increments each cycle; on byte_cnt=3, fetch_pc += 4 and byte_cnt → 0.
- A new instruction (byte_cnt=0) starts only when count + (instruction under assembly ? 1 : 0) < DEPTH; otherwise → HOLD. A same-cycle pop is not counted. HOLD → ISSUE on the first cycle the condition holds.
- Return path: when rd_pending, asm ← {asm[23:0], imem_rdata}. On the 4th byte, push {asm[23:0], imem_rdata} with the PC of that instruction.
- Byte 0 is the MSB: memory bytes 4C 40 00 11 → 0x4C400011.
- Pop when out_valid && out_ready. Push and pop in the same cycle are both performed.
- out_instr/out_pc show the FIFO head; they are 0 when the FIFO is empty.
- redirect (sampled at the edge) has priority over push, pop and issue:
  - clear FIFO and count
  - drop the byte returning next cycle (rd_pending ← 0)
  - fetch_pc ← {redirect_pc[ADDR_W-1:2], 2'b00}; misaligned targets are truncated
  - byte_cnt ← 0, state ← ISSUE
- PC arithmetic wraps modulo 2^ADDR_W.

## Timing
- Reset values: imem_en=0, imem_addr=0, out_valid=0, out_instr=0, out_pc=0, fetch_pc=RESET_PC, byte_cnt=0, count=0, rd_pending=0. Assertion takes effect immediately, mid-fetch included.
- First cycle after rst deasserts (cycle 0): imem_en=1, addr=RESET_PC. Bytes issue in cycles 0–3, return in cycles 1–4, the push happens at the end of cycle 4, and out_valid=1 in cycle 5.
- Steady state with out_ready=1: one instruction every 4 cycles, no gaps; out_pc increments by 4.
- Redirect asserted in cycle N: imem_addr=target in cycle N+1, out_valid=0 in N+1..N+5, first redirected instruction valid in N+6.
- Redirect in the same cycle as a pop: the pop is discarded, the FIFO is empty next cycle, and the consumer must ignore the instruction it sampled.
- With full FIFO and out_ready held low: imem_en stays 0 and the head is stable; no instruction is lost or duplicated.

## Test plan
- Reset → sequential fetch: memory 4C 40 00 11 | 4C 80 00 10 at 0 → out (0x4C400011, pc 0) in cycle 5, then (0x4C800010, pc 4) 4 cycles later.
- Backpressure: out_ready=0 for 30 cycles → exactly DEPTH entries held (pcs 0, 4), imem_en=0 once full. Release → pcs 0, 4, 8, … in order, no gaps or repeats.
- Redirect mid-assembly: redirect to 0x14 while byte_cnt=2 of pc 8 → no output for pc 8. Next out is (0x4D000100, pc 0x14) in cycle N+6, followed by (0x4C C0 00 01 = 0x4CC00001, pc 0x18).
- Misaligned redirect to 0x15 → imem_addr 0x14 next cycle; out_pc 0x14.
- Async reset mid-fetch: drop rst between clock edges during byte 1 → outputs reach reset values immediately. Release → refetch from RESET_PC.
- Simultaneous: full FIFO with pop and redirect in the same edge → FIFO empty next cycle, first new instruction from redirect_pc.

Source files
------------

// File: rtl/if_byte_fetch.sv
// rtl/if_byte_fetch.sv - byte-serial instruction fetch with big-endian assembly and output FIFO
// Issues four byte reads per instruction, packs them MSB-first and queues {instr, pc} for decode.
module if_byte_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [0:0] ST_HOLD  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [0:0]        state_q,      state_d;
  logic [ADDR_W-1:0] fetch_pc_q,   fetch_pc_d;
  logic [1:0]        byte_cnt_q,   byte_cnt_d;
  logic [31:0]       asm_q,        asm_d;
  logic              rd_pending_q, rd_pending_d;
  logic              rd_last_q,    rd_last_d;
  logic [CNT_W-1:0]  count_q,      count_d;
  logic [PTR_W-1:0]  rd_ptr_q,     rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q,     wr_ptr_d;

  logic [31:0]       instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem    [DEPTH];

  logic              issue;
  logic              under_asm;
  logic [CNT_W:0]    occ;
  logic              start_ok;
  logic              push;
  logic              pop;
  logic [31:0]       push_instr;
  logic [ADDR_W-1:0] push_pc;

  // Outputs are decoded from registered state so reset clears them without a combinational path.
  assign issue     = (state_q == ST_ISSUE);
  assign imem_en   = issue;
  assign imem_addr = issue ? (fetch_pc_q + {{(ADDR_W-2){1'b0}}, byte_cnt_q}) : '0;

  // An instruction still being issued or returning reserves a FIFO slot; a same-cycle pop does not free one.
  assign under_asm = issue | rd_pending_q;
  assign occ       = {1'b0, count_q} + {{CNT_W{1'b0}}, under_asm};
  assign start_ok  = (occ < (CNT_W+1)'(DEPTH));

  assign out_valid  = (count_q != '0);
  assign out_instr  = out_valid ? instr_mem[rd_ptr_q] : '0;
  assign out_pc     = out_valid ? pc_mem[rd_ptr_q]    : '0;

  // fetch_pc already advanced past this instruction when its last byte was issued.
  assign push_instr = {asm_q[23:0], imem_rdata};
  assign push_pc    = fetch_pc_q - ADDR_W'(4);
  assign push       = rd_pending_q & rd_last_q & ~redirect;
  assign pop        = out_valid & out_ready & ~redirect;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    rd_pending_d = issue;
    rd_last_d    = issue && (byte_cnt_q == 2'd3);
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;

    if (rd_pending_q) begin
      asm_d = push_instr;
    end

    if (issue) begin
      if (byte_cnt_q == 2'd3) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        byte_cnt_d = 2'd0;
        state_d    = start_ok ? ST_ISSUE : ST_HOLD;
      end else begin
        byte_cnt_d = byte_cnt_q + 2'd1;
      end
    end else begin
      state_d = start_ok ? ST_ISSUE : ST_HOLD;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (redirect) begin
      count_d      = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      rd_pending_d = 1'b0;
      rd_last_d    = 1'b0;
      fetch_pc_d   = {redirect_pc[ADDR_W-1:2], 2'b00};
      byte_cnt_d   = 2'd0;
      state_d      = ST_ISSUE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_HOLD;
      fetch_pc_q   <= RESET_PC;
      byte_cnt_q   <= 2'd0;
      asm_q        <= '0;
      rd_pending_q <= 1'b0;
      rd_last_q    <= 1'b0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      rd_pending_q <= rd_pending_d;
      rd_last_q    <= rd_last_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= push_instr;
      pc_mem[wr_ptr_q]    <= push_pc;
    end
  end

endmodule

// File: tb/tb_if_byte_fetch.sv
// tb/tb_if_byte_fetch.sv - directed self-checking bench for if_byte_fetch
// Byte memory responds one cycle after each request; outputs are sampled on the falling edge.
module tb_if_byte_fetch;

  logic        clk;
  logic        rst;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [7:0]  imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  logic [7:0]  mem [256];
  int          n_cmp;
  int          n_err;
  int          n_got;
  logic [31:0] exp_pc;

  if_byte_fetch #(.ADDR_W(32), .DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr[7:0]];
  end

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    logic [7:0] a;
    a = pc[7:0];
    return {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at the falling edge of cycle 0 (first request cycle).
  task automatic do_reset();
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b1;
    imem_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    {mem[0],  mem[1],  mem[2],  mem[3]}  = 32'h4C400011;
    {mem[4],  mem[5],  mem[6],  mem[7]}  = 32'h4C800010;
    {mem[20], mem[21], mem[22], mem[23]} = 32'h4D000100;
    {mem[24], mem[25], mem[26], mem[27]} = 32'h4CC00001;

    // Reset state
    @(negedge clk);
    cyc(1);
    check("rst_en",    64'(imem_en),   64'd0);
    check("rst_addr",  64'(imem_addr), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_instr", 64'(out_instr), 64'd0);
    check("rst_pc",    64'(out_pc),    64'd0);

    // Sequential fetch
    rst = 1'b1;
    cyc(1);
    check("c0_en",   64'(imem_en),   64'd1);
    check("c0_addr", 64'(imem_addr), 64'd0);
    cyc(1);
    check("c1_addr", 64'(imem_addr), 64'd1);
    cyc(3);
    check("c4_valid", 64'(out_valid), 64'd0);
    cyc(1);
    check("c5_valid", 64'(out_valid), 64'd1);
    check("c5_instr", 64'(out_instr), 64'h4C400011);
    check("c5_pc",    64'(out_pc),    64'h0);
    cyc(1);
    check("c6_valid", 64'(out_valid), 64'd0);
    cyc(3);
    check("c9_valid", 64'(out_valid), 64'd1);
    check("c9_instr", 64'(out_instr), 64'h4C800010);
    check("c9_pc",    64'(out_pc),    64'h4);

    // Backpressure
    out_ready = 1'b0;
    do_reset();
    cyc(25);
    check("bp_en25",  64'(imem_en),   64'd0);
    check("bp_pc25",  64'(out_pc),    64'h0);
    cyc(5);
    check("bp_en30",  64'(imem_en),   64'd0);
    check("bp_val30", 64'(out_valid), 64'd1);
    check("bp_ins30", 64'(out_instr), 64'h4C400011);
    check("bp_pc30",  64'(out_pc),    64'h0);
    out_ready = 1'b1;
    exp_pc = 32'h0;
    n_got = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        check("bp_seq_pc",    64'(out_pc),    64'(exp_pc));
        check("bp_seq_instr", 64'(out_instr), 64'(exp_instr(exp_pc)));
        exp_pc = exp_pc + 32'd4;
        n_got++;
      end
      cyc(1);
    end
    check("bp_progress", 64'(n_got >= 8), 64'd1);

    // Redirect while byte 2 of pc 8 is issued (cycle 10)
    do_reset();
    cyc(10);
    check("rd_pre_addr", 64'(imem_addr), 64'hA);
    redirect = 1'b1;
    redirect_pc = 32'h14;
    cyc(1);
    redirect = 1'b0;
    check("rd_n1_addr", 64'(imem_addr), 64'h14);
    check("rd_n1_en",   64'(imem_en),   64'd1);
    for (int i = 1; i <= 5; i++) begin
      check("rd_gap_valid", 64'(out_valid), 64'd0);
      if (i < 5) cyc(1);
    end
    cyc(1);
    check("rd_n6_valid", 64'(out_valid), 64'd1);
    check("rd_n6_instr", 64'(out_instr), 64'h4D000100);
    check("rd_n6_pc",    64'(out_pc),    64'h14);
    cyc(4);
    check("rd_n10_valid", 64'(out_valid), 64'd1);
    check("rd_n10_instr", 64'(out_instr), 64'h4CC00001);
    check("rd_n10_pc",    64'(out_pc),    64'h18);

    // Misaligned redirect, concurrent with a pop
    redirect = 1'b1;
    redirect_pc = 32'h15;
    cyc(1);
    redirect = 1'b0;
    check("mis_addr",  64'(imem_addr), 64'h14);
    check("mis_valid", 64'(out_valid), 64'd0);
    cyc(5);
    check("mis_pc",    64'(out_pc),    64'h14);
    check("mis_instr", 64'(out_instr), 64'h4D000100);

    // Asynchronous reset between edges, during byte 1 of pc 4
    out_ready = 1'b0;
    do_reset();
    cyc(5);
    check("ar_pre_addr",  64'(imem_addr), 64'h5);
    check("ar_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_en",    64'(imem_en),   64'd0);
    check("ar_addr",  64'(imem_addr), 64'd0);
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_instr", 64'(out_instr), 64'd0);
    check("ar_pc",    64'(out_pc),    64'd0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    cyc(1);
    check("ar_c0_en",   64'(imem_en),   64'd1);
    check("ar_c0_addr", 64'(imem_addr), 64'd0);
    cyc(5);
    check("ar_c5_instr", 64'(out_instr), 64'h4C400011);
    check("ar_c5_pc",    64'(out_pc),    64'h0);

    // Full FIFO, pop and redirect on the same edge
    out_ready = 1'b0;
    do_reset();
    cyc(30);
    check("sim_full_en", 64'(imem_en), 64'd0);
    check("sim_full_pc", 64'(out_pc),  64'h0);
    out_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h14;
    cyc(1);
    redirect = 1'b0;
    check("sim_n1_valid", 64'(out_valid), 64'd0);
    check("sim_n1_addr",  64'(imem_addr), 64'h14);
    cyc(5);
    check("sim_n6_valid", 64'(out_valid), 64'd1);
    check("sim_n6_pc",    64'(out_pc),    64'h14);
    check("sim_n6_instr", 64'(out_instr), 64'h4D000100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
